// File: rtl/dac_sample_fifo_if.sv
// rtl/dac_sample_fifo_if.sv - push and DAC-side signal bundle for dac_sample_fifo
interface dac_sample_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          push_data;
  logic                push_valid;
  logic                push_ready;
  logic [7:0]          dac_data;
  logic                dac_ack;
  logic                hold_mode;
  logic [DEPTH_LOG2:0] level;
  logic                underrun;
  logic                underrun_clr;

  modport master (
    output push_data, push_valid, dac_ack, hold_mode, underrun_clr,
    input  push_ready, dac_data, level, underrun
  );

  modport slave (
    input  push_data, push_valid, dac_ack, hold_mode, underrun_clr,
    output push_ready, dac_data, level, underrun
  );
endinterface

// File: rtl/dac_sample_fifo.sv
// rtl/dac_sample_fifo.sv - sample FIFO with presentation register feeding the PWM DAC
module dac_sample_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  dac_sample_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [7:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  pres_valid_q, pres_valid_d;
  logic [7:0]            dac_data_q, dac_data_d;
  logic                  underrun_q, underrun_d;
  logic                  push, pop, empty, push_ready;

  assign push_ready   = (count_q != CNT_FULL);
  assign empty        = (count_q == '0);
  assign bus.push_ready = push_ready;
  assign bus.dac_data   = dac_data_q;
  assign bus.level      = level_q;
  assign bus.underrun   = underrun_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pres_valid_d = pres_valid_q;
    dac_data_d   = dac_data_q;
    pop          = 1'b0;
    push         = bus.push_valid && push_ready;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;

    // Ack always consumes the presented sample; with nothing behind it, fall back to filler.
    if (bus.dac_ack) begin
      if (!empty) begin
        pop = 1'b1;
      end else begin
        pres_valid_d = 1'b0;
        if (!bus.hold_mode) dac_data_d = 8'h00;
      end
    end else if (!pres_valid_q && !empty) begin
      pop = 1'b1;
    end

    if (pop) begin
      dac_data_d   = mem[rd_ptr_q];
      rd_ptr_d     = rd_ptr_q + PTR_ONE;
      pres_valid_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    level_d = count_d + {{DEPTH_LOG2{1'b0}}, pres_valid_d};

    // A filler acknowledge beats a simultaneous clear so no underrun is lost.
    if (bus.dac_ack && !pres_valid_q) underrun_d = 1'b1;
    else if (bus.underrun_clr)        underrun_d = 1'b0;
    else                              underrun_d = underrun_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      level_q      <= '0;
      pres_valid_q <= 1'b0;
      dac_data_q   <= 8'h00;
      underrun_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      level_q      <= level_d;
      pres_valid_q <= pres_valid_d;
      dac_data_q   <= dac_data_d;
      underrun_q   <= underrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.push_data;
  end
endmodule

// File: doc/dac_sample_fifo.md
# dac_sample_fifo

Sample buffer that sits directly upstream of the PWM DAC. It accepts signed 8-bit speech samples from the synthesis datapath over a valid/ready push interface. It presents one sample at a time to the DAC's pull interface (`din`/`din_ack`) and advances on each DAC acknowledge. Underrun behaviour is selectable, and underruns are reported through a sticky flag, so the DAC always has a defined input.

## Interface
- `DEPTH_LOG2`, default 4: FIFO storage is 2^DEPTH_LOG2 entries (16). Legal range is 2..8.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `push_data` in 8: signed sample from the synthesizer.
- `push_valid` in 1: `push_data` is valid this cycle.
- `push_ready` out 1: FIFO can accept a sample. A push occurs when `push_valid & push_ready` at a rising edge.
- `dac_data` out 8: signed sample presented to the DAC `din`. Registered.
- `dac_ack` in 1: the DAC `din_ack`. High for one cycle after the DAC has latched `dac_data`.
- `hold_mode` in 1: underrun filler select. 1 repeats the last sample; 0 outputs 0.
- `level` out DEPTH_LOG2+1: FIFO occupancy plus 1 if the presented sample is valid. Registered.
- `underrun` out 1: sticky. Set when the DAC acknowledged a filler sample.
- `underrun_clr` in 1: synchronous clear of `underrun`.

## Operation
- Storage consists of a circular RAM of 2^DEPTH_LOG2 × 8 bits plus a presentation register (`dac_data`, `pres_valid`).
- Pointers `wr_ptr` and `rd_ptr` are DEPTH_LOG2 bits wide and wrap modulo depth.
- `count` is DEPTH_LOG2+1 bits wide and ranges from 0 to 2^DEPTH_LOG2.
- `push_ready = (count != 2^DEPTH_LOG2)`. It is a function of registered `count` only and does not look ahead at same-cycle pops.
- Push: write `mem[wr_ptr]`, then `wr_ptr++`. There is no bypass into the presentation register.
- Pop (into the presentation register) is evaluated each cycle in priority order:
  1. If `dac_ack=1` and `count>0`: `dac_data <= mem[rd_ptr]`, `rd_ptr++`, `pres_valid <= 1`.
  2. If `dac_ack=1` and `count==0`: `pres_valid <= 0`. `dac_data` keeps its value if `hold_mode=1`, else `dac_data <= 0`.
  3. If `dac_ack=0`, `pres_valid=0` and `count>0` (prefetch): `dac_data <= mem[rd_ptr]`, `rd_ptr++`, `pres_valid <= 1`.
  4. Otherwise no change.
- Filler stability: while `pres_valid=0` and the FIFO is empty, `dac_data` does not change, even if `hold_mode` toggles. `hold_mode` is sampled only in case 2.
- `count` update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop in the same cycle: unchanged.
- Simultaneous push and pop when `count==2^DEPTH_LOG2` cannot occur because `push_ready=0`.
- Simultaneous push and prefetch with `count==0` cannot occur because prefetch requires `count>0`. The pushed sample is prefetched on the following cycle.
- `level = count + pres_valid`, registered from next-state values. Maximum value is 2^DEPTH_LOG2+1.
- `underrun`:
  - Set on a cycle where `dac_ack=1` and `pres_valid=0`. This means the DAC latched a filler.
  - Cleared by `underrun_clr=1`.
  - Set wins over clear in the same cycle.
- `dac_ack` held high on consecutive cycles is legal. Each cycle counts as one consumption.

## Timing
- Reset (asynchronous, while `rst=1`):
  - `wr_ptr`, `rd_ptr`, `count` = 0.
  - `pres_valid` = 0.
  - `dac_data` = 8'h00.
  - `level` = 0.
  - `underrun` = 0.
  - `push_ready` = 1 (combinational from `count`).
  - RAM contents are not reset.
- Reset asserted mid-stream discards all buffered samples. The DAC sees 0 from the reset instant.
- Push-to-present latency into an empty block: push at edge N; `count=1` after N; prefetch at edge N+1; `dac_data` is valid and `level=1` after N+1.
- Ack-to-next-sample: `dac_ack` high in cycle C, the new `dac_data` is visible after the edge ending C. This is one cycle, well within the DAC's 256-cycle period.
- `dac_data` changes only:
  - on a prefetch,
  - on an ack cycle,
  - on reset.
- `dac_data` is never changed while `pres_valid=1` and `dac_ack=0`.
- `push_ready` deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after a pop from full.

## Test plan
- Reset: assert `rst` mid-stream with `level=5` → `dac_data=0`, `level=0`, `underrun=0`, `push_ready=1` immediately. After release, a push of 0x12 yields `dac_data=0x12` two edges later.
- Ordering: push −128, −1, 0, 127, then pulse `dac_ack` 4 times spaced 256 cycles apart → the DAC latches −128, −1, 0, 127 in order. `level` steps 4,3,2,1,0.
- Full: with `DEPTH_LOG2=4`, push 17 samples 0..16 back-to-back with no ack → `push_ready=0` after 17 accepted (16 in RAM + 1 presented), `level=17`. One ack → `push_ready=1` next cycle. The 18th push is accepted; data order is preserved across pointer wrap over 40 samples.
- Underrun, hold: `hold_mode=1`, present 0x55, ack with FIFO empty → `dac_data` stays 0x55, `pres_valid=0`, `underrun=0`. A second ack → `underrun=1`.
- Underrun, zero: `hold_mode=0`, same sequence → `dac_data=0x00` after the first ack. The second ack sets `underrun`. Assert `underrun_clr` in the same cycle as a third filler ack → `underrun` remains 1. Clear alone → 0.
- Push during ack: `count=1`, push 0x33 in the same cycle as `dac_ack` → `count` stays 1, `dac_data` = the old head, and 0x33 is presented on the next ack.
